// File: rtl/register_file.sv
// Dual-read, single-write register file with registered read ports, optional
// write-to-read forwarding, synchronous clear and asynchronous reset.
module register_file #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  in,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr0,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [WIDTH-1:0]  out0,
    output logic [WIDTH-1:0]  out1,
    output logic              out_valid
);

    localparam int              NWORDS  = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

    // Read view spans the full address space; words at or above DEPTH read as 0.
    logic [WIDTH-1:0]  w_words [NWORDS];
    logic [ADDR_W-1:0] w_raddr [2];
    logic              w_wr_ok;
    logic              r_valid;

    assign w_wr_ok    = we && !clr && ({1'b0, waddr} < DEPTH_W);
    assign w_raddr[0] = raddr0;
    assign w_raddr[1] = raddr1;

    genvar gi;
    generate
        for (gi = 0; gi < NWORDS; gi++) begin : g_word
            if (gi < DEPTH) begin : g_store
                logic [WIDTH-1:0] r_word;

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_word <= '0;
                    end else if (clr) begin
                        r_word <= '0;
                    end else if (w_wr_ok && (waddr == ADDR_W'(gi))) begin
                        r_word <= in;
                    end
                end

                assign w_words[gi] = r_word;
            end else begin : g_empty
                assign w_words[gi] = '0;
            end
        end

        for (gi = 0; gi < 2; gi++) begin : g_port
            logic [WIDTH-1:0] w_rdata;
            logic [WIDTH-1:0] r_out;

            if (BYPASS != 0) begin : g_fwd
                // Forward what the storage will hold after this edge.
                always_comb begin
                    w_rdata = w_words[w_raddr[gi]];
                    if (clr) begin
                        w_rdata = '0;
                    end else if (w_wr_ok && (waddr == w_raddr[gi])) begin
                        w_rdata = in;
                    end
                end
            end else begin : g_nofwd
                assign w_rdata = w_words[w_raddr[gi]];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_out <= '0;
                end else if (re) begin
                    r_out <= w_rdata;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= re;
        end
    end

    assign out0      = g_port[0].r_out;
    assign out1      = g_port[1].r_out;
    assign out_valid = r_valid;

endmodule

// File: tb/tb_register_file.sv
// Directed bench: three instances (forwarding, no forwarding, DEPTH=6) share
// one stimulus stream; each task checks the instance its scenario targets.
module tb_register_file;

    logic        clk;
    logic        rst_n;
    logic        clr;
    logic        we;
    logic [2:0]  waddr;
    logic [15:0] in;
    logic        re;
    logic [2:0]  raddr0;
    logic [2:0]  raddr1;

    logic [15:0] out0_a, out1_a, out0_b, out1_b, out0_c, out1_c;
    logic        vld_a, vld_b, vld_c;

    int n_checks = 0;
    int n_errors = 0;

    register_file #(.WIDTH(16), .DEPTH(8), .ADDR_W(3), .BYPASS(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .clr(clr), .we(we), .waddr(waddr), .in(in),
        .re(re), .raddr0(raddr0), .raddr1(raddr1),
        .out0(out0_a), .out1(out1_a), .out_valid(vld_a)
    );

    register_file #(.WIDTH(16), .DEPTH(8), .ADDR_W(3), .BYPASS(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .clr(clr), .we(we), .waddr(waddr), .in(in),
        .re(re), .raddr0(raddr0), .raddr1(raddr1),
        .out0(out0_b), .out1(out1_b), .out_valid(vld_b)
    );

    register_file #(.WIDTH(16), .DEPTH(6), .ADDR_W(3), .BYPASS(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .clr(clr), .we(we), .waddr(waddr), .in(in),
        .re(re), .raddr0(raddr0), .raddr1(raddr1),
        .out0(out0_c), .out1(out1_c), .out_valid(vld_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 1'b0; clr = 1'b0; re = 1'b0;
    endtask

    task automatic write_word(input logic [2:0] a, input logic [15:0] d);
        we = 1'b1; clr = 1'b0; re = 1'b0; waddr = a; in = d;
        tick();
        we = 1'b0;
        $display("write addr=%0d data=%h", a, d);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        we = 1'b1; clr = 1'b0; re = 1'b1; waddr = 3'd1; in = 16'hFFFF;
        raddr0 = 3'd1; raddr1 = 3'd1;
        repeat (2) tick();
        n_checks++;
        if (out0_a !== 16'h0 || out1_a !== 16'h0 || vld_a !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_a out0=%h out1=%h vld=%b exp 0/0/0", out0_a, out1_a, vld_a);
        end
        n_checks++;
        if (out0_b !== 16'h0 || vld_b !== 1'b0 || out0_c !== 16'h0 || vld_c !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_bc out0_b=%h vld_b=%b out0_c=%h vld_c=%b exp 0", out0_b, vld_b, out0_c, vld_c);
        end
        idle();
        #2 rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            re = 1'b1; raddr0 = 3'(i); raddr1 = 3'(7 - i);
            tick();
            $display("read r0=%0d r1=%0d out0=%h out1=%h vld=%b", i, 7 - i, out0_a, out1_a, vld_a);
            n_checks++;
            if (out0_a !== 16'h0 || out1_a !== 16'h0 || vld_a !== 1'b1) begin
                n_errors++;
                $display("FAIL reset_sweep addr=%0d out0=%h out1=%h vld=%b exp 0/0/1", i, out0_a, out1_a, vld_a);
            end
        end
        re = 1'b0;
        tick();
        n_checks++;
        if (vld_a !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_vld_drop vld=%b exp 0", vld_a);
        end
    endtask

    task automatic test_write_read();
        write_word(3'd3, 16'hA5A5);
        write_word(3'd7, 16'h1234);
        re = 1'b1; raddr0 = 3'd3; raddr1 = 3'd7;
        tick();
        $display("read r0=3 r1=7 out0=%h out1=%h vld=%b", out0_a, out1_a, vld_a);
        n_checks++;
        if (out0_a !== 16'hA5A5 || out1_a !== 16'h1234 || vld_a !== 1'b1) begin
            n_errors++;
            $display("FAIL write_read out0=%h out1=%h vld=%b exp a5a5/1234/1", out0_a, out1_a, vld_a);
        end
        n_checks++;
        if (out0_c !== 16'hA5A5 || out1_c !== 16'h0000) begin
            n_errors++;
            $display("FAIL write_read_d6 out0=%h out1=%h exp a5a5/0000", out0_c, out1_c);
        end
        // re low: outputs hold even though addresses move
        re = 1'b0; raddr0 = 3'd0; raddr1 = 3'd0;
        tick();
        n_checks++;
        if (out0_a !== 16'hA5A5 || out1_a !== 16'h1234 || vld_a !== 1'b0) begin
            n_errors++;
            $display("FAIL hold out0=%h out1=%h vld=%b exp a5a5/1234/0", out0_a, out1_a, vld_a);
        end
    endtask

    task automatic test_same_addr();
        re = 1'b1; raddr0 = 3'd7; raddr1 = 3'd7;
        tick();
        re = 1'b0;
        $display("read r0=7 r1=7 out0=%h out1=%h", out0_a, out1_a);
        n_checks++;
        if (out0_a !== 16'h1234 || out1_a !== 16'h1234) begin
            n_errors++;
            $display("FAIL same_addr out0=%h out1=%h exp 1234/1234", out0_a, out1_a);
        end
    endtask

    task automatic test_bypass();
        write_word(3'd2, 16'h0001);
        we = 1'b1; waddr = 3'd2; in = 16'hBEEF;
        re = 1'b1; raddr0 = 3'd2; raddr1 = 3'd3;
        tick();
        we = 1'b0;
        $display("write+read addr=2 fwd_out0=%h nofwd_out0=%h", out0_a, out0_b);
        n_checks++;
        if (out0_a !== 16'hBEEF || out1_a !== 16'hA5A5) begin
            n_errors++;
            $display("FAIL bypass_on out0=%h out1=%h exp beef/a5a5", out0_a, out1_a);
        end
        n_checks++;
        if (out0_b !== 16'h0001 || out1_b !== 16'hA5A5) begin
            n_errors++;
            $display("FAIL bypass_off out0=%h out1=%h exp 0001/a5a5", out0_b, out1_b);
        end
        raddr0 = 3'd2;
        tick();
        re = 1'b0;
        n_checks++;
        if (out0_a !== 16'hBEEF || out0_b !== 16'hBEEF) begin
            n_errors++;
            $display("FAIL bypass_after fwd=%h nofwd=%h exp beef/beef", out0_a, out0_b);
        end
    endtask

    task automatic test_clear();
        for (int i = 0; i < 8; i++) write_word(3'(i), 16'hFFFF);
        clr = 1'b1; we = 1'b1; waddr = 3'd5; in = 16'h7777;
        re = 1'b1; raddr0 = 3'd5; raddr1 = 3'd0;
        tick();
        clr = 1'b0; we = 1'b0;
        $display("clear+write+read fwd=%h/%h nofwd=%h/%h", out0_a, out1_a, out0_b, out1_b);
        n_checks++;
        if (out0_a !== 16'h0 || out1_a !== 16'h0 || vld_a !== 1'b1) begin
            n_errors++;
            $display("FAIL clear_fwd out0=%h out1=%h vld=%b exp 0/0/1", out0_a, out1_a, vld_a);
        end
        n_checks++;
        if (out0_b !== 16'hFFFF || out1_b !== 16'hFFFF) begin
            n_errors++;
            $display("FAIL clear_nofwd out0=%h out1=%h exp ffff/ffff", out0_b, out1_b);
        end
        for (int i = 0; i < 8; i++) begin
            raddr0 = 3'(i); raddr1 = 3'(7 - i);
            tick();
            n_checks++;
            if (out0_a !== 16'h0 || out1_a !== 16'h0 || out0_b !== 16'h0 || out1_b !== 16'h0) begin
                n_errors++;
                $display("FAIL clear_sweep addr=%0d fwd=%h/%h nofwd=%h/%h exp 0", i, out0_a, out1_a, out0_b, out1_b);
            end
        end
        re = 1'b0;
    endtask

    task automatic test_out_of_range();
        for (int i = 0; i < 6; i++) write_word(3'(i), 16'h1000 + 16'(i));
        write_word(3'd6, 16'h5555);
        re = 1'b1; raddr0 = 3'd6; raddr1 = 3'd7;
        tick();
        $display("read r0=6 r1=7 d6=%h/%h d8=%h/%h", out0_c, out1_c, out0_a, out1_a);
        n_checks++;
        if (out0_c !== 16'h0 || out1_c !== 16'h0 || vld_c !== 1'b1) begin
            n_errors++;
            $display("FAIL oor_d6 out0=%h out1=%h vld=%b exp 0/0/1", out0_c, out1_c, vld_c);
        end
        n_checks++;
        if (out0_a !== 16'h5555 || out1_a !== 16'h0) begin
            n_errors++;
            $display("FAIL oor_d8 out0=%h out1=%h exp 5555/0000", out0_a, out1_a);
        end
        for (int i = 0; i < 6; i++) begin
            raddr0 = 3'(i); raddr1 = 3'(5 - i);
            tick();
            n_checks++;
            if (out0_c !== 16'h1000 + 16'(i) || out1_c !== 16'h1000 + 16'(5 - i)) begin
                n_errors++;
                $display("FAIL oor_intact addr=%0d out0=%h out1=%h exp %h/%h", i, out0_c, out1_c,
                         16'h1000 + 16'(i), 16'h1000 + 16'(5 - i));
            end
        end
        re = 1'b0;
    endtask

    task automatic test_async_reset();
        write_word(3'd3, 16'hA5A5);
        re = 1'b1; raddr0 = 3'd3; raddr1 = 3'd3;
        tick();
        n_checks++;
        if (out0_a !== 16'hA5A5 || vld_a !== 1'b1) begin
            n_errors++;
            $display("FAIL areset_pre out0=%h vld=%b exp a5a5/1", out0_a, vld_a);
        end
        #2 rst_n = 1'b0;
        #1;
        $display("async reset mid-cycle out0=%h vld=%b", out0_a, vld_a);
        n_checks++;
        if (out0_a !== 16'h0 || vld_a !== 1'b0 || out0_b !== 16'h0) begin
            n_errors++;
            $display("FAIL areset_now out0=%h vld=%b out0_b=%h exp 0/0/0", out0_a, vld_a, out0_b);
        end
        tick();
        n_checks++;
        if (vld_a !== 1'b0) begin
            n_errors++;
            $display("FAIL areset_held vld=%b exp 0", vld_a);
        end
        re = 1'b0;
        #2 rst_n = 1'b1;
        tick();
        n_checks++;
        if (vld_a !== 1'b0) begin
            n_errors++;
            $display("FAIL areset_first_edge vld=%b exp 0", vld_a);
        end
        re = 1'b1; raddr0 = 3'd3; raddr1 = 3'd7;
        tick();
        re = 1'b0;
        n_checks++;
        if (out0_a !== 16'h0 || out1_a !== 16'h0 || vld_a !== 1'b1) begin
            n_errors++;
            $display("FAIL areset_readback out0=%h out1=%h vld=%b exp 0/0/1", out0_a, out1_a, vld_a);
        end
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b0; we = 1'b0; re = 1'b0;
        waddr = 3'd0; in = 16'h0; raddr0 = 3'd0; raddr1 = 3'd0;
        test_reset();
        test_write_read();
        test_same_addr();
        test_bypass();
        test_clear();
        test_out_of_range();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
